// File: rtl/axis_tb_arb_if.sv
// AXI4-Stream bundle carrying N parallel lanes; N=1 for the shared output,
// N=S_COUNT for the packed source side of the arbiter.
interface axis_tb_arb_if #(
    parameter int N          = 1,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1
);
    logic [N*DATA_WIDTH-1:0] tdata;
    logic [N*KEEP_WIDTH-1:0] tkeep;
    logic [N-1:0]            tvalid;
    logic [N-1:0]            tready;
    logic [N-1:0]            tlast;
    logic [N*USER_WIDTH-1:0] tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_tb_credit.sv
// Per-source token bucket: signed credit accumulator, saturating at the
// configured positive cap and at the most negative representable value.
module axis_tb_credit #(
    parameter int CREDIT_WIDTH = 24,
    parameter int INC_WIDTH    = 16,
    parameter int DEBIT_WIDTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           tick,
    input  logic        [INC_WIDTH-1:0]    inc,
    input  logic        [DEBIT_WIDTH-1:0]  debit,
    input  logic        [CREDIT_WIDTH-1:0] max,
    output logic signed [CREDIT_WIDTH-1:0] credit,
    output logic                           eligible_ok
);
    // Two guard bits so credit + inc - debit can never wrap before saturation.
    localparam int SUM_WIDTH = ((CREDIT_WIDTH > INC_WIDTH) ? CREDIT_WIDTH : INC_WIDTH) + 2;

    logic signed [SUM_WIDTH-1:0] credit_ext;
    logic signed [SUM_WIDTH-1:0] inc_ext;
    logic signed [SUM_WIDTH-1:0] debit_ext;
    logic signed [SUM_WIDTH-1:0] sum;

    function automatic logic signed [CREDIT_WIDTH-1:0] sat(
        input logic signed [SUM_WIDTH-1:0]    v,
        input logic        [CREDIT_WIDTH-1:0] hi
    );
        logic signed [SUM_WIDTH-1:0] hi_ext;
        logic signed [SUM_WIDTH-1:0] lo_ext;
        hi_ext = $signed({{(SUM_WIDTH-CREDIT_WIDTH){1'b0}}, hi});
        lo_ext = $signed({{(SUM_WIDTH-CREDIT_WIDTH+1){1'b1}}, {(CREDIT_WIDTH-1){1'b0}}});
        if (v > hi_ext)
            return $signed(hi);
        else if (v < lo_ext)
            return $signed({1'b1, {(CREDIT_WIDTH-1){1'b0}}});
        else
            return $signed(v[CREDIT_WIDTH-1:0]);
    endfunction

    assign credit_ext = $signed({{(SUM_WIDTH-CREDIT_WIDTH){credit[CREDIT_WIDTH-1]}}, credit});
    assign inc_ext    = tick ? $signed({{(SUM_WIDTH-INC_WIDTH){1'b0}}, inc}) : '0;
    assign debit_ext  = $signed({{(SUM_WIDTH-DEBIT_WIDTH){1'b0}}, debit});
    assign sum        = credit_ext + inc_ext - debit_ext;

    always_ff @(posedge clk) begin
        if (rst)
            credit <= '0;
        else
            credit <= sat(sum, max);
    end

    assign eligible_ok = ~credit[CREDIT_WIDTH-1];
endmodule

// File: rtl/axis_tb_arb.sv
// Frame-granular round-robin AXI4-Stream arbiter with a token bucket per
// source; the granted source is muxed straight through with no buffering.
module axis_tb_arb #(
    parameter int S_COUNT        = 4,
    parameter int DATA_WIDTH     = 64,
    parameter bit KEEP_ENABLE    = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int USER_WIDTH     = 1,
    parameter int CREDIT_WIDTH   = 24,
    parameter int INC_WIDTH      = 16,
    parameter int PRESCALE_WIDTH = 8,
    localparam int CL_WIDTH      = $clog2(S_COUNT)
) (
    input  logic                             clk,
    input  logic                             rst,
    axis_tb_arb_if.slave                     s_axis,
    axis_tb_arb_if.master                    m_axis,
    input  logic                             enable,
    input  logic [PRESCALE_WIDTH-1:0]        prescale,
    input  logic [S_COUNT*INC_WIDTH-1:0]     rate_inc,
    input  logic [S_COUNT*CREDIT_WIDTH-1:0]  bucket_max,
    output logic                             grant_valid,
    output logic [CL_WIDTH-1:0]              grant_index,
    output logic [S_COUNT-1:0]               credit_neg
);
    localparam int CNT_WIDTH = $clog2(KEEP_WIDTH + 1);

    typedef enum logic {ARB_IDLE, ARB_ACTIVE} arb_state_t;

    arb_state_t                  state;
    logic [CL_WIDTH-1:0]         rr_ptr;
    logic [PRESCALE_WIDTH-1:0]   pre_cnt;
    logic                        tick;
    logic                        beat_acc;
    logic                        sel_last;
    logic [S_COUNT-1:0]          elig_ok;
    logic [S_COUNT-1:0]          eligible;
    logic [S_COUNT-1:0]          ready_vec;

    logic        [DATA_WIDTH-1:0]   tdata_arr [S_COUNT];
    logic        [KEEP_WIDTH-1:0]   tkeep_arr [S_COUNT];
    logic        [USER_WIDTH-1:0]   tuser_arr [S_COUNT];
    logic        [CNT_WIDTH-1:0]    debit     [S_COUNT];
    logic signed [CREDIT_WIDTH-1:0] credit    [S_COUNT];

    function automatic logic [CNT_WIDTH-1:0] byte_count(input logic [KEEP_WIDTH-1:0] keep);
        logic [CNT_WIDTH-1:0] n;
        n = '0;
        if (KEEP_ENABLE) begin
            for (int k = 0; k < KEEP_WIDTH; k++)
                n = n + CNT_WIDTH'(keep[k]);
        end else begin
            n = CNT_WIDTH'(KEEP_WIDTH);
        end
        return n;
    endfunction

    function automatic logic [CL_WIDTH-1:0] rr_pick(
        input logic [S_COUNT-1:0]  req,
        input logic [CL_WIDTH-1:0] ptr
    );
        logic [CL_WIDTH-1:0] sel;
        logic                found;
        int                  idx;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < S_COUNT; k++) begin
            idx = int'(ptr) + k;
            if (idx >= S_COUNT)
                idx = idx - S_COUNT;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = CL_WIDTH'(idx);
            end
        end
        return sel;
    endfunction

    function automatic logic [CL_WIDTH-1:0] next_idx(input logic [CL_WIDTH-1:0] idx);
        return (idx == CL_WIDTH'(S_COUNT - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Shared tick divider; the >= keeps it from running away if prescale shrinks.
    assign tick = (pre_cnt >= prescale);

    always_ff @(posedge clk) begin
        if (rst)
            pre_cnt <= '0;
        else
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end

    assign beat_acc = grant_valid & s_axis.tvalid[grant_index] & m_axis.tready;
    assign sel_last = s_axis.tlast[grant_index];

    for (genvar i = 0; i < S_COUNT; i++) begin : g_src
        assign tdata_arr[i] = s_axis.tdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign tkeep_arr[i] = s_axis.tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        assign tuser_arr[i] = s_axis.tuser[i*USER_WIDTH +: USER_WIDTH];
        assign debit[i]     = (beat_acc && grant_index == CL_WIDTH'(i)) ?
                              byte_count(tkeep_arr[i]) : '0;

        axis_tb_credit #(
            .CREDIT_WIDTH (CREDIT_WIDTH),
            .INC_WIDTH    (INC_WIDTH),
            .DEBIT_WIDTH  (CNT_WIDTH)
        ) u_credit (
            .clk          (clk),
            .rst          (rst),
            .tick         (tick),
            .inc          (rate_inc[i*INC_WIDTH +: INC_WIDTH]),
            .debit        (debit[i]),
            .max          (bucket_max[i*CREDIT_WIDTH +: CREDIT_WIDTH]),
            .credit       (credit[i]),
            .eligible_ok  (elig_ok[i])
        );

        assign credit_neg[i] = credit[i][CREDIT_WIDTH-1];
        assign eligible[i]   = s_axis.tvalid[i] & elig_ok[i];
    end

    // Grants are taken only at frame boundaries; the frame is never cut.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            grant_valid <= 1'b0;
            grant_index <= '0;
            rr_ptr      <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (enable && |eligible) begin
                        grant_index <= rr_pick(eligible, rr_ptr);
                        grant_valid <= 1'b1;
                        state       <= ARB_ACTIVE;
                    end
                end
                ARB_ACTIVE: begin
                    if (beat_acc && sel_last) begin
                        grant_valid <= 1'b0;
                        rr_ptr      <= next_idx(grant_index);
                        state       <= ARB_IDLE;
                    end
                end
                default: begin
                    state       <= ARB_IDLE;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        ready_vec = '0;
        if (grant_valid && m_axis.tready)
            ready_vec[grant_index] = 1'b1;
    end

    assign s_axis.tready = ready_vec;
    assign m_axis.tdata  = tdata_arr[grant_index];
    assign m_axis.tkeep  = tkeep_arr[grant_index];
    assign m_axis.tuser  = tuser_arr[grant_index];
    assign m_axis.tlast  = sel_last;
    assign m_axis.tvalid = grant_valid & s_axis.tvalid[grant_index];
endmodule

// File: tb/tb_axis_tb_arb.sv
// Randomised bench for axis_tb_arb: per-cycle comparison against a token
// bucket / round-robin reference model kept in plain integer arithmetic.
module tb_axis_tb_arb;
    localparam int S  = 4;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int CW = 24;
    localparam int IW = 16;

    logic           clk;
    logic           rst;
    logic           enable;
    logic [7:0]     prescale;
    logic [S*IW-1:0] rate_inc;
    logic [S*CW-1:0] bucket_max;
    logic           grant_valid;
    logic [1:0]     grant_index;
    logic [S-1:0]   credit_neg;

    axis_tb_arb_if #(.N(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(1)) s_if ();
    axis_tb_arb_if #(.N(1), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(1)) m_if ();

    axis_tb_arb #(
        .S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(1),
        .CREDIT_WIDTH(CW), .INC_WIDTH(IW), .PRESCALE_WIDTH(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .enable      (enable),
        .prescale    (prescale),
        .rate_inc    (rate_inc),
        .bucket_max  (bucket_max),
        .grant_valid (grant_valid),
        .grant_index (grant_index),
        .credit_neg  (credit_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model state
    int cr [S];
    int pc;
    bit gv;
    int gi;
    int rr;
    logic [S-1:0] acc;
    int beats;

    // Stimulus knobs
    int pv, pl, tr_pct, en_pct, rst_pml;
    bit full_keep;
    logic [S-1:0] mask;

    task automatic model_reset();
        for (int i = 0; i < S; i++) cr[i] = 0;
        pc = 0; gv = 0; gi = 0; rr = 0;
    endtask

    task automatic cycle();
        logic         exp_mv;
        logic [S-1:0] exp_sr, exp_neg, elig;
        bit           tick, found;
        int           v, deb, idx, mx;
        @(negedge clk);
        exp_mv = gv && s_if.tvalid[gi];
        exp_sr = '0;
        if (gv && m_if.tready) exp_sr[gi] = 1'b1;
        for (int i = 0; i < S; i++) begin
            exp_neg[i] = (cr[i] < 0);
            elig[i]    = s_if.tvalid[i] && (cr[i] >= 0);
        end
        check("grant", {grant_valid, grant_index}, {gv, 2'(gi)});
        check("m_tvalid", m_if.tvalid, exp_mv);
        check("s_tready", s_if.tready, exp_sr);
        check("credit_neg", credit_neg, exp_neg);
        if (exp_mv)
            check("m_beat", {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser},
                  {s_if.tdata[gi*DW +: DW], s_if.tkeep[gi*KW +: KW], s_if.tlast[gi], s_if.tuser[gi]});
        if (m_if.tvalid && m_if.tready) beats++;
        acc = exp_sr & s_if.tvalid;

        if (rst) begin
            model_reset();
        end else begin
            tick = (pc >= int'(prescale));
            pc   = tick ? 0 : pc + 1;
            for (int i = 0; i < S; i++) begin
                deb = acc[i] ? $countones(s_if.tkeep[i*KW +: KW]) : 0;
                mx  = int'(bucket_max[i*CW +: CW]);
                v   = cr[i] + (tick ? int'(rate_inc[i*IW +: IW]) : 0) - deb;
                if (v > mx) v = mx;
                if (v < -(1 << (CW-1))) v = -(1 << (CW-1));
                cr[i] = v;
            end
            if (!gv) begin
                if (enable && |elig) begin
                    found = 0;
                    for (int k = 0; k < S; k++) begin
                        idx = (rr + k) % S;
                        if (!found && elig[idx]) begin found = 1; gi = idx; end
                    end
                    gv = 1;
                end
            end else if (exp_mv && m_if.tready && s_if.tlast[gi]) begin
                gv = 0;
                rr = (gi + 1) % S;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < S; i++) begin
            if (!s_if.tvalid[i] || acc[i]) begin
                s_if.tvalid[i] = mask[i] && (($urandom % 100) < pv);
                s_if.tdata[i*DW +: DW] = {$urandom, $urandom};
                s_if.tkeep[i*KW +: KW] = full_keep ? 8'hFF : 8'($urandom_range(1, 255));
                s_if.tlast[i] = (($urandom % 100) < pl);
                s_if.tuser[i] = 1'($urandom);
            end
        end
        m_if.tready = (($urandom % 100) < tr_pct);
        enable      = (($urandom % 100) < en_pct);
    endtask

    task automatic set_cfg(input int inc [S], input int mx [S], input int pre);
        for (int i = 0; i < S; i++) begin
            rate_inc[i*IW +: IW]   = 16'(inc[i]);
            bucket_max[i*CW +: CW] = 24'(mx[i]);
        end
        prescale = 8'(pre);
    endtask

    task automatic start_phase();
        rst = 1'b1;
        s_if.tvalid = '0;
        acc = '0;
        cycle();
        cycle();
        check("rst_state", {grant_valid, m_if.tvalid, s_if.tready, credit_neg}, '0);
        rst = 1'b0;
        beats = 0;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            cycle();
            if (rst_pml > 0)
                rst = (($urandom % 1000) < rst_pml);
        end
        rst = 1'b0;
    endtask

    int inc_c [S];
    int max_c [S];

    initial begin
        rst = 1'b1; enable = 1'b0; prescale = '0; rate_inc = '0; bucket_max = '0;
        s_if.tdata = '0; s_if.tkeep = '0; s_if.tvalid = '0; s_if.tlast = '0; s_if.tuser = '0;
        m_if.tready = 1'b0;
        model_reset(); acc = '0; beats = 0;
        pv = 100; pl = 50; tr_pct = 100; en_pct = 100; rst_pml = 0; full_keep = 0; mask = '1;

        // No refill: each source sends one frame, then stays negative forever.
        for (int i = 0; i < S; i++) begin inc_c[i] = 0; max_c[i] = 0; end
        set_cfg(inc_c, max_c, 0);
        start_phase();
        run(60);

        // Plenty of credit, single-beat frames: strict rotation.
        for (int i = 0; i < S; i++) begin inc_c[i] = 100; max_c[i] = 1000; end
        set_cfg(inc_c, max_c, 0);
        pl = 100; full_keep = 1;
        start_phase();
        run(80);

        // Rate limited source 1 only: 2 bytes per 4 cycles.
        for (int i = 0; i < S; i++) begin inc_c[i] = 0; max_c[i] = 1000; end
        inc_c[1] = 2;
        set_cfg(inc_c, max_c, 3);
        mask = 4'b0010;
        start_phase();
        run(1600);
        check("throughput_in_range", (beats >= 99 && beats <= 101), 1'b1);

        // Randomised configurations with back-pressure, enable gaps and resets.
        mask = '1; full_keep = 0; pv = 70; pl = 30; tr_pct = 60; en_pct = 85;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < S; i++) begin
                inc_c[i] = $urandom_range(0, 40);
                max_c[i] = $urandom_range(0, 300);
            end
            set_cfg(inc_c, max_c, $urandom_range(0, 5));
            rst_pml = 0;
            start_phase();
            rst_pml = 3;
            run(2500);
        end

        // Long frames with enable toggling frequently.
        for (int i = 0; i < S; i++) begin inc_c[i] = 20; max_c[i] = 500; end
        set_cfg(inc_c, max_c, 1);
        pl = 15; tr_pct = 50; en_pct = 30; rst_pml = 0;
        start_phase();
        run(1500);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
